// File: rtl/turfio_aurora_link_watchdog.sv
// Aurora link supervisor: watches channel_up_i and issues system and GT reset requests,
// escalating to a GT reset once repeated system resets fail to bring the link up.
`timescale 1ns/1ps
module turfio_aurora_link_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned RST_HOLD       = 16,
    parameter int unsigned GT_HOLD        = 64,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned DROP_FILTER    = 4
) (
    input  logic        user_clk_i,
    input  logic        gt_rst_sync,
    input  logic        enable_i,
    input  logic        channel_up_i,
    input  logic        force_reset_i,
    output logic        reset_req_o,
    output logic        gt_reset_req_o,
    output logic        link_ok_o,
    output logic [3:0]  retry_count_o,
    output logic [15:0] drop_count_o,
    output logic [1:0]  state_o
);

    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW  = $clog2(DROP_FILTER + 1);
    localparam int RHW = $clog2(RST_HOLD);
    localparam int GHW = $clog2(GT_HOLD + 1);

    if (RST_HOLD < 8) begin : g_chk_rst_hold
        $error("RST_HOLD must be at least 8");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_chk_max_retry
        $error("MAX_RETRY must be in 1..15");
    end
    if (DROP_FILTER < 1) begin : g_chk_drop_filter
        $error("DROP_FILTER must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_WAIT_UP = 2'd0,
        ST_UP      = 2'd1,
        ST_SYS_RST = 2'd2,
        ST_GT_RST  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   filter_q, filter_d;
    logic [RHW-1:0]  rst_hold_q, rst_hold_d;
    logic [GHW-1:0]  gt_hold_q, gt_hold_d;
    logic [3:0]      retry_q, retry_d;
    logic [15:0]     drop_q, drop_d;
    logic            abort_q, abort_d;
    logic            reset_req_q, reset_req_d;
    logic            gt_reset_req_q, gt_reset_req_d;
    logic            link_ok_q, link_ok_d;
    logic            enter_sys;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        filter_d   = filter_q;
        rst_hold_d = rst_hold_q;
        gt_hold_d  = gt_hold_q;
        retry_d    = retry_q;
        drop_d     = drop_q;
        abort_d    = abort_q;
        enter_sys  = 1'b0;

        case (state_q)
            ST_WAIT_UP: begin
                if (!enable_i) begin
                    timer_d = '0;
                end else if (channel_up_i) begin
                    state_d  = ST_UP;
                    timer_d  = '0;
                    filter_d = '0;
                end else if (force_reset_i || timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    enter_sys = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_UP: begin
                if (!enable_i) begin
                    state_d  = ST_WAIT_UP;
                    timer_d  = '0;
                    filter_d = '0;
                end else if (force_reset_i) begin
                    enter_sys = 1'b1;
                end else if (!channel_up_i && filter_q == FW'(DROP_FILTER - 1)) begin
                    enter_sys = 1'b1;
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end else begin
                    filter_d = channel_up_i ? '0 : filter_q + FW'(1);
                    // The stable timer parks at TIMEOUT_CYCLES so the retry clear fires once.
                    if (timer_q != TW'(TIMEOUT_CYCLES)) begin
                        timer_d = timer_q + TW'(1);
                        if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            retry_d = '0;
                        end
                    end
                end
            end
            ST_SYS_RST: begin
                if (!enable_i) begin
                    abort_d = 1'b1;
                end
                rst_hold_d = rst_hold_q + RHW'(1);
                if (rst_hold_q == RHW'(RST_HOLD - 1)) begin
                    rst_hold_d = '0;
                    if (retry_q >= 4'(MAX_RETRY) && enable_i && !abort_q) begin
                        state_d   = ST_GT_RST;
                        gt_hold_d = '0;
                    end else begin
                        state_d = ST_WAIT_UP;
                        timer_d = '0;
                    end
                end
            end
            default: begin
                if (gt_hold_q != GHW'(GT_HOLD)) begin
                    gt_hold_d = gt_hold_q + GHW'(1);
                end
            end
        endcase

        if (enter_sys) begin
            state_d    = ST_SYS_RST;
            rst_hold_d = '0;
            abort_d    = 1'b0;
            filter_d   = '0;
            timer_d    = '0;
            if (retry_q != 4'hF) begin
                retry_d = retry_q + 4'd1;
            end
        end

        reset_req_d    = (state_d == ST_SYS_RST);
        gt_reset_req_d = (state_d == ST_GT_RST) && (gt_hold_d != GHW'(GT_HOLD));
        link_ok_d      = (state_d == ST_UP);
    end

    always_ff @(posedge user_clk_i or posedge gt_rst_sync) begin
        if (gt_rst_sync) begin
            state_q        <= ST_WAIT_UP;
            timer_q        <= '0;
            filter_q       <= '0;
            rst_hold_q     <= '0;
            gt_hold_q      <= '0;
            retry_q        <= '0;
            drop_q         <= '0;
            abort_q        <= 1'b0;
            reset_req_q    <= 1'b0;
            gt_reset_req_q <= 1'b0;
            link_ok_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            filter_q       <= filter_d;
            rst_hold_q     <= rst_hold_d;
            gt_hold_q      <= gt_hold_d;
            retry_q        <= retry_d;
            drop_q         <= drop_d;
            abort_q        <= abort_d;
            reset_req_q    <= reset_req_d;
            gt_reset_req_q <= gt_reset_req_d;
            link_ok_q      <= link_ok_d;
        end
    end

    assign reset_req_o    = reset_req_q;
    assign gt_reset_req_o = gt_reset_req_q;
    assign link_ok_o      = link_ok_q;
    assign retry_count_o  = retry_q;
    assign drop_count_o   = drop_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_turfio_aurora_link_watchdog.sv
// Bench for the Aurora link watchdog: directed sessions with literal expectations plus a
// phase/age model of the supervisor that is compared against the outputs every cycle.
`timescale 1ns/1ps
module tb_turfio_aurora_link_watchdog;

    localparam int TIMEOUT_CYCLES = 100;
    localparam int RST_HOLD       = 8;
    localparam int GT_HOLD        = 16;
    localparam int MAX_RETRY      = 2;
    localparam int DROP_FILTER    = 4;

    logic        user_clk_i    = 1'b0;
    logic        gt_rst_sync   = 1'b1;
    logic        enable_i      = 1'b0;
    logic        channel_up_i  = 1'b0;
    logic        force_reset_i = 1'b0;
    logic        reset_req_o;
    logic        gt_reset_req_o;
    logic        link_ok_o;
    logic [3:0]  retry_count_o;
    logic [15:0] drop_count_o;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 user_clk_i = ~user_clk_i;

    turfio_aurora_link_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .RST_HOLD      (RST_HOLD),
        .GT_HOLD       (GT_HOLD),
        .MAX_RETRY     (MAX_RETRY),
        .DROP_FILTER   (DROP_FILTER)
    ) dut (
        .user_clk_i    (user_clk_i),
        .gt_rst_sync   (gt_rst_sync),
        .enable_i      (enable_i),
        .channel_up_i  (channel_up_i),
        .force_reset_i (force_reset_i),
        .reset_req_o   (reset_req_o),
        .gt_reset_req_o(gt_reset_req_o),
        .link_ok_o     (link_ok_o),
        .retry_count_o (retry_count_o),
        .drop_count_o  (drop_count_o),
        .state_o       (state_o)
    );

    // Model: phase is the supervisor mode, age counts cycles spent in it since entry.
    int mPhase   = 0;
    int mAge     = 0;
    int mZeros   = 0;
    int mRetries = 0;
    int mDrops   = 0;
    bit mAbort   = 1'b0;

    function void enterPhase(input int p);
        mPhase = p;
        mAge   = 0;
        mZeros = 0;
        if (p == 2) begin
            mAbort = 1'b0;
            if (mRetries < 15) mRetries = mRetries + 1;
        end
    endfunction

    initial begin
        forever begin
            @(posedge user_clk_i or posedge gt_rst_sync);
            if (gt_rst_sync) begin
                mPhase = 0; mAge = 0; mZeros = 0; mRetries = 0; mDrops = 0; mAbort = 1'b0;
            end else begin
                case (mPhase)
                    0: begin
                        if (!enable_i) mAge = 0;
                        else if (channel_up_i) enterPhase(1);
                        else if (force_reset_i || mAge == TIMEOUT_CYCLES - 1) enterPhase(2);
                        else mAge = mAge + 1;
                    end
                    1: begin
                        if (!enable_i) enterPhase(0);
                        else if (force_reset_i) enterPhase(2);
                        else if (!channel_up_i && mZeros + 1 == DROP_FILTER) begin
                            if (mDrops < 65535) mDrops = mDrops + 1;
                            enterPhase(2);
                        end else begin
                            mZeros = channel_up_i ? 0 : mZeros + 1;
                            if (mAge + 1 == TIMEOUT_CYCLES) mRetries = 0;
                            mAge = mAge + 1;
                        end
                    end
                    2: begin
                        if (!enable_i) mAbort = 1'b1;
                        if (mAge + 1 == RST_HOLD)
                            enterPhase((mRetries >= MAX_RETRY && !mAbort) ? 3 : 0);
                        else
                            mAge = mAge + 1;
                    end
                    default: mAge = mAge + 1;
                endcase
            end
        end
    end

    logic [24:0] dutVec;
    logic [24:0] modelVec;
    assign dutVec   = {state_o, link_ok_o, reset_req_o, gt_reset_req_o, retry_count_o, drop_count_o};
    assign modelVec = {2'(mPhase), (mPhase == 1), (mPhase == 2),
                       (mPhase == 3 && mAge < GT_HOLD), 4'(mRetries), 16'(mDrops)};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge user_clk_i) begin
        checkOutput($sformatf("model_c%0d", cyc), 32'(dutVec), 32'(modelVec));
    end

    // Inputs for cycle n are driven just after edge n-1; the call returns mid-cycle n.
    task automatic applyStimulus(input logic en, input logic up, input logic frc);
        @(posedge user_clk_i);
        #1;
        enable_i      = en;
        channel_up_i  = up;
        force_reset_i = frc;
        cyc           = cyc + 1;
        @(negedge user_clk_i);
        #1;
    endtask

    task automatic runUntil(input int n, input logic en, input logic up, input logic frc);
        while (cyc < n) applyStimulus(en, up, frc);
    endtask

    task automatic releaseReset(input logic en, input logic up);
        @(negedge user_clk_i);
        #1;
        enable_i      = en;
        channel_up_i  = up;
        force_reset_i = 1'b0;
        gt_rst_sync   = 1'b0;
        cyc           = 1;
    endtask

    task automatic assertReset(input string name);
        gt_rst_sync = 1'b1;
        #1;
        checkOutput(name, 32'(dutVec), 0);
        repeat (3) @(negedge user_clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout reached at cycle %0d", cyc);
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        repeat (3) @(negedge user_clk_i);
        #1;
        checkOutput("reset_state", 32'(dutVec), 0);

        // Session A: link up, filtered glitch, real drop, forced reset, disable mid-hold.
        $display("[TB] session A");
        releaseReset(1'b1, 1'b0);
        runUntil(19, 1'b1, 1'b0, 1'b0);
        runUntil(20, 1'b1, 1'b1, 1'b0);
        checkOutput("A_c20_link", 32'(link_ok_o), 0);
        runUntil(21, 1'b1, 1'b1, 1'b0);
        checkOutput("A_c21_link", 32'(link_ok_o), 1);
        checkOutput("A_c21_state", 32'(state_o), 1);
        checkOutput("A_c21_reqs", 32'({reset_req_o, gt_reset_req_o}), 0);
        runUntil(29, 1'b1, 1'b1, 1'b0);
        runUntil(32, 1'b1, 1'b0, 1'b0);
        runUntil(34, 1'b1, 1'b1, 1'b0);
        checkOutput("A_c34_nodrop", 32'(drop_count_o), 0);
        checkOutput("A_c34_state", 32'(state_o), 1);
        runUntil(39, 1'b1, 1'b1, 1'b0);
        runUntil(43, 1'b1, 1'b0, 1'b0);
        checkOutput("A_c43_rr", 32'(reset_req_o), 0);
        runUntil(44, 1'b1, 1'b0, 1'b0);
        checkOutput("A_c44_drop", 32'(drop_count_o), 1);
        checkOutput("A_c44_rr", 32'(reset_req_o), 1);
        checkOutput("A_c44_retry", 32'(retry_count_o), 1);
        checkOutput("A_c44_state", 32'(state_o), 2);
        runUntil(51, 1'b1, 1'b0, 1'b0);
        checkOutput("A_c51_rr", 32'(reset_req_o), 1);
        runUntil(52, 1'b1, 1'b1, 1'b0);
        checkOutput("A_c52_rr", 32'(reset_req_o), 0);
        checkOutput("A_c52_state", 32'(state_o), 0);
        runUntil(59, 1'b1, 1'b1, 1'b0);
        runUntil(60, 1'b1, 1'b1, 1'b1);
        runUntil(61, 1'b1, 1'b1, 1'b0);
        checkOutput("A_c61_rr", 32'(reset_req_o), 1);
        checkOutput("A_c61_retry", 32'(retry_count_o), 2);
        checkOutput("A_c61_drop", 32'(drop_count_o), 1);
        checkOutput("A_c61_pin_model_retry", 32'(mRetries), 2);
        runUntil(62, 1'b1, 1'b1, 1'b0);
        runUntil(68, 1'b0, 1'b0, 1'b0);
        checkOutput("A_c68_rr", 32'(reset_req_o), 1);
        runUntil(69, 1'b0, 1'b0, 1'b0);
        checkOutput("A_c69_rr", 32'(reset_req_o), 0);
        checkOutput("A_c69_state", 32'(state_o), 0);
        checkOutput("A_c69_gr", 32'(gt_reset_req_o), 0);
        checkOutput("A_c69_pin_model_phase", 32'(mPhase), 0);
        runUntil(99, 1'b0, 1'b0, 1'b0);
        runUntil(100, 1'b0, 1'b0, 1'b1);
        runUntil(149, 1'b0, 1'b0, 1'b0);
        runUntil(150, 1'b0, 1'b0, 1'b1);
        runUntil(219, 1'b0, 1'b0, 1'b0);
        checkOutput("A_c219_reqs", 32'({reset_req_o, gt_reset_req_o}), 0);
        checkOutput("A_c219_state", 32'(state_o), 0);
        runUntil(221, 1'b1, 1'b1, 1'b0);
        checkOutput("A_c221_state", 32'(state_o), 1);
        runUntil(320, 1'b1, 1'b1, 1'b0);
        checkOutput("A_c320_retry", 32'(retry_count_o), 2);
        runUntil(321, 1'b1, 1'b1, 1'b0);
        checkOutput("A_c321_retry", 32'(retry_count_o), 0);
        checkOutput("A_c321_pin_model_retry", 32'(mRetries), 0);
        runUntil(330, 1'b1, 1'b1, 1'b0);
        assertReset("A_async_reset");

        // Session B: link never comes up, escalation to GT reset, then reset clears it.
        $display("[TB] session B");
        releaseReset(1'b1, 1'b0);
        runUntil(100, 1'b1, 1'b0, 1'b0);
        checkOutput("B_c100_rr", 32'(reset_req_o), 0);
        runUntil(101, 1'b1, 1'b0, 1'b0);
        checkOutput("B_c101_rr", 32'(reset_req_o), 1);
        checkOutput("B_c101_retry", 32'(retry_count_o), 1);
        runUntil(108, 1'b1, 1'b0, 1'b0);
        checkOutput("B_c108_rr", 32'(reset_req_o), 1);
        runUntil(109, 1'b1, 1'b0, 1'b0);
        checkOutput("B_c109_rr", 32'(reset_req_o), 0);
        checkOutput("B_c109_state", 32'(state_o), 0);
        runUntil(209, 1'b1, 1'b0, 1'b0);
        checkOutput("B_c209_rr", 32'(reset_req_o), 1);
        checkOutput("B_c209_retry", 32'(retry_count_o), 2);
        runUntil(216, 1'b1, 1'b0, 1'b0);
        checkOutput("B_c216_rr", 32'(reset_req_o), 1);
        runUntil(217, 1'b1, 1'b0, 1'b0);
        checkOutput("B_c217_state", 32'(state_o), 3);
        checkOutput("B_c217_gr", 32'(gt_reset_req_o), 1);
        checkOutput("B_c217_rr", 32'(reset_req_o), 0);
        checkOutput("B_c217_pin_model_phase", 32'(mPhase), 3);
        runUntil(232, 1'b1, 1'b0, 1'b0);
        checkOutput("B_c232_gr", 32'(gt_reset_req_o), 1);
        runUntil(233, 1'b1, 1'b0, 1'b0);
        checkOutput("B_c233_gr", 32'(gt_reset_req_o), 0);
        checkOutput("B_c233_state", 32'(state_o), 3);
        runUntil(235, 1'b1, 1'b1, 1'b0);
        runUntil(236, 1'b1, 1'b1, 1'b1);
        runUntil(240, 1'b1, 1'b1, 1'b0);
        checkOutput("B_c240_state", 32'(state_o), 3);
        checkOutput("B_c240_reqs", 32'({reset_req_o, gt_reset_req_o}), 0);
        assertReset("B_gt_reset_clear");

        // Session C: channel_up on the timeout cycle, disable in UP, force priorities.
        $display("[TB] session C");
        releaseReset(1'b1, 1'b0);
        runUntil(99, 1'b1, 1'b0, 1'b0);
        runUntil(101, 1'b1, 1'b1, 1'b0);
        checkOutput("C_c101_state", 32'(state_o), 1);
        checkOutput("C_c101_rr", 32'(reset_req_o), 0);
        runUntil(102, 1'b0, 1'b1, 1'b0);
        runUntil(103, 1'b1, 1'b1, 1'b0);
        checkOutput("C_c103_state", 32'(state_o), 0);
        checkOutput("C_c103_link", 32'(link_ok_o), 0);
        runUntil(104, 1'b1, 1'b1, 1'b0);
        checkOutput("C_c104_state", 32'(state_o), 1);
        runUntil(105, 1'b1, 1'b1, 1'b1);
        runUntil(106, 1'b1, 1'b1, 1'b0);
        checkOutput("C_c106_rr", 32'(reset_req_o), 1);
        checkOutput("C_c106_retry", 32'(retry_count_o), 1);
        checkOutput("C_c106_drop", 32'(drop_count_o), 0);
        runUntil(107, 1'b1, 1'b1, 1'b0);
        runUntil(108, 1'b1, 1'b1, 1'b1);
        runUntil(113, 1'b1, 1'b1, 1'b0);
        checkOutput("C_c113_rr", 32'(reset_req_o), 1);
        runUntil(114, 1'b1, 1'b1, 1'b1);
        checkOutput("C_c114_rr", 32'(reset_req_o), 0);
        checkOutput("C_c114_state", 32'(state_o), 0);
        runUntil(115, 1'b1, 1'b1, 1'b1);
        checkOutput("C_c115_state", 32'(state_o), 1);
        checkOutput("C_c115_rr", 32'(reset_req_o), 0);
        runUntil(116, 1'b1, 1'b1, 1'b0);
        checkOutput("C_c116_rr", 32'(reset_req_o), 1);
        checkOutput("C_c116_retry", 32'(retry_count_o), 2);
        runUntil(123, 1'b1, 1'b1, 1'b0);
        checkOutput("C_c123_rr", 32'(reset_req_o), 1);
        runUntil(124, 1'b1, 1'b1, 1'b0);
        checkOutput("C_c124_state", 32'(state_o), 3);
        checkOutput("C_c124_gr", 32'(gt_reset_req_o), 1);
        checkOutput("C_c124_rr", 32'(reset_req_o), 0);
        runUntil(130, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
